// File: rtl/pause_pkg.sv
// Shared definitions for the pause / dim controller: FSM state encoding
// and the production timing defaults (48 MHz system clock).
package pause_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_FADE = 2'd2,
        ST_DIM  = 2'd3
    } pause_state_t;

    // 10 s of user pause before the picture starts to fade
    localparam int DEF_DIM_CYCLES       = 480000000;
    // 100 ms between successive dim levels
    localparam int DEF_FADE_STEP_CYCLES = 4800000;

endpackage

// File: rtl/rgb_dimmer.sv
// Registered per-channel dimmer: each colour field of the packed {b,g,r}
// pixel is shifted right independently, so no bits leak between channels.
module rgb_dimmer #(
    parameter int RW = 3,
    parameter int GW = 3,
    parameter int BW = 2,
    parameter int LW = 1
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic [RW+GW+BW-1:0]   i_rgb,
    input  logic [LW-1:0]         i_shift,
    output logic [RW+GW+BW-1:0]   o_rgb
);

    logic [RW-1:0] w_r;
    logic [GW-1:0] w_g;
    logic [BW-1:0] w_b;

    assign w_r = i_rgb[0 +: RW] >> i_shift;
    assign w_g = i_rgb[RW +: GW] >> i_shift;
    assign w_b = i_rgb[RW+GW +: BW] >> i_shift;

    // register the dimmed pixel, one cycle behind the input
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            o_rgb <= '0;
        end else begin
            o_rgb <= {w_b, w_g, w_r};
        end
    end

endmodule

// File: rtl/pause_dim_ctrl.sv
// Pause and screen-dim controller.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   RUN   | not user-paused, picture at full brightness
//   HOLD  | user-paused, counting up to the dim delay
//   FADE  | stepping dim_level up once every FADE_STEP_CYCLES
//   DIM   | fully dimmed, held until the user un-pauses
//
// External requests only drive the pause output; they never dim.
module pause_dim_ctrl
    import pause_pkg::*;
#(
    parameter int NREQ             = 3,
    parameter int RW               = 3,
    parameter int GW               = 3,
    parameter int BW               = 2,
    parameter int DIM_CYCLES       = DEF_DIM_CYCLES,
    parameter int DIM_LEVELS       = 1,
    parameter int FADE_STEP_CYCLES = DEF_FADE_STEP_CYCLES
) (
    input  logic                               clk_sys,
    input  logic                               reset_n,
    input  logic                               btn_pause,
    input  logic [NREQ-1:0]                    req,
    input  logic [NREQ-1:0]                    req_en,
    input  logic [RW+GW+BW-1:0]                rgb_in,
    output logic [RW+GW+BW-1:0]                rgb_out,
    output logic                               pause,
    output logic                               user_paused,
    output logic [$clog2(DIM_LEVELS+1)-1:0]    dim_level
);

    localparam int LW = $clog2(DIM_LEVELS + 1);
    localparam int TW = (DIM_CYCLES > 1) ? $clog2(DIM_CYCLES) : 1;
    localparam int SW = (FADE_STEP_CYCLES > 1) ? $clog2(FADE_STEP_CYCLES) : 1;

    localparam logic [TW-1:0] TIMER_LAST = TW'(DIM_CYCLES - 1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(FADE_STEP_CYCLES - 1);
    localparam logic [LW-1:0] LVL_MAX    = LW'(DIM_LEVELS);
    localparam logic [LW-1:0] LVL_ONE    = LW'(1);

    logic              r_btn_s1;
    logic              r_btn_s2;
    logic              r_btn_prev;
    logic [2:0]        r_arm;
    logic              r_user_paused;
    logic              r_pause;
    pause_state_t      r_state;
    logic [TW-1:0]     r_timer;
    logic [SW-1:0]     r_step;
    logic [LW-1:0]     r_dim_level;

    logic              w_toggle;
    logic              w_up_next;
    logic              w_req_any;

    // Edge detection is held off until the synchroniser has refilled after
    // reset, so a button held down through reset does not read as a press.
    assign w_toggle  = r_arm[2] & r_btn_s2 & ~r_btn_prev;
    assign w_up_next = r_user_paused ^ w_toggle;
    assign w_req_any = |(req & req_en);

    // two-flop button synchroniser plus edge-detect history
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_btn_s1   <= 1'b0;
            r_btn_s2   <= 1'b0;
            r_btn_prev <= 1'b0;
            r_arm      <= 3'b000;
        end else begin
            r_btn_s1   <= btn_pause;
            r_btn_s2   <= r_btn_s1;
            r_btn_prev <= r_btn_s2;
            r_arm      <= {r_arm[1:0], 1'b1};
        end
    end

    // user pause toggle and combined pause output
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_user_paused <= 1'b0;
            r_pause       <= 1'b0;
        end else begin
            r_user_paused <= w_up_next;
            r_pause       <= w_up_next | w_req_any;
        end
    end

    // dim sequencing FSM; an un-pause overrides every boundary transition
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_RUN;
            r_timer     <= '0;
            r_step      <= '0;
            r_dim_level <= '0;
        end else if (!w_up_next) begin
            r_state     <= ST_RUN;
            r_timer     <= '0;
            r_step      <= '0;
            r_dim_level <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_state     <= ST_HOLD;
                    r_timer     <= '0;
                    r_step      <= '0;
                    r_dim_level <= '0;
                end
                ST_HOLD: begin
                    if (r_timer == TIMER_LAST) begin
                        r_dim_level <= LVL_ONE;
                        r_step      <= '0;
                        r_state     <= (LVL_MAX == LVL_ONE) ? ST_DIM : ST_FADE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_FADE: begin
                    if (r_step == STEP_LAST) begin
                        r_step      <= '0;
                        r_dim_level <= r_dim_level + LVL_ONE;
                        if ((r_dim_level + LVL_ONE) == LVL_MAX) begin
                            r_state <= ST_DIM;
                        end
                    end else begin
                        r_step <= r_step + SW'(1);
                    end
                end
                ST_DIM: begin
                    r_dim_level <= LVL_MAX;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    rgb_dimmer #(
        .RW (RW),
        .GW (GW),
        .BW (BW),
        .LW (LW)
    ) u_rgb_dimmer (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .i_rgb   (rgb_in),
        .i_shift (r_dim_level),
        .o_rgb   (rgb_out)
    );

    assign pause       = r_pause;
    assign user_paused = r_user_paused;
    assign dim_level   = r_dim_level;

endmodule

// File: tb/tb_pause_dim_ctrl.sv
// Directed bench for pause_dim_ctrl with short timing parameters.
module tb_pause_dim_ctrl;
    import pause_pkg::*;

    logic           clk_sys;
    logic           reset_n;
    logic           btn_pause;
    logic [2:0]     req;
    logic [2:0]     req_en;
    logic [7:0]     rgb_in;
    logic [7:0]     rgb_out;
    logic           pause;
    logic           user_paused;
    logic [1:0]     dim_level;

    int             n_tests;
    int             n_fail;
    logic [1:0]     dim_seen;

    pause_dim_ctrl #(
        .NREQ             (3),
        .RW               (3),
        .GW               (3),
        .BW               (2),
        .DIM_CYCLES       (100),
        .DIM_LEVELS       (2),
        .FADE_STEP_CYCLES (10)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .btn_pause   (btn_pause),
        .req         (req),
        .req_en      (req_en),
        .rgb_in      (rgb_in),
        .rgb_out     (rgb_out),
        .pause       (pause),
        .user_paused (user_paused),
        .dim_level   (dim_level)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance n clock edges, sampling 1 ns after each edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            #1;
            if (dim_level > dim_seen) dim_seen = dim_level;
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        dim_seen  = 2'd0;
        reset_n   = 1'b0;
        btn_pause = 1'b0;
        req       = 3'b000;
        req_en    = 3'b111;
        rgb_in    = 8'hFF;

        // reset state
        tick(2);
        chk("rst_rgb",   rgb_out, 8'h00);
        chk("rst_up",    user_paused, 1'b0);
        chk("rst_pause", pause, 1'b0);
        chk("rst_dim",   dim_level, 2'd0);
        chk("rst_state", dut.r_state, ST_RUN);
        reset_n = 1'b1;
        tick(5);

        // press -> toggle after 3 edges, hold 100 cycles, fade in 10-cycle steps
        btn_pause = 1'b1;
        tick(2);
        chk("up_early", user_paused, 1'b0);
        tick(1);
        chk("up_set",     user_paused, 1'b1);
        chk("pause_set",  pause, 1'b1);
        chk("hold_state", dut.r_state, ST_HOLD);
        chk("hold_rgb",   rgb_out, 8'hFF);
        tick(99);
        chk("hold_end_state", dut.r_state, ST_HOLD);
        chk("hold_end_dim",   dim_level, 2'd0);
        chk("hold_end_rgb",   rgb_out, 8'hFF);
        tick(1);
        chk("fade_state", dut.r_state, ST_FADE);
        chk("fade_dim1",  dim_level, 2'd1);
        chk("fade_rgb_lag", rgb_out, 8'hFF);
        tick(1);
        chk("fade_rgb1", rgb_out, 8'h5B);
        tick(8);
        chk("fade_dim1_end", dim_level, 2'd1);
        tick(1);
        chk("dim_dim2",  dim_level, 2'd2);
        chk("dim_state", dut.r_state, ST_DIM);
        tick(1);
        chk("dim_rgb2", rgb_out, 8'h09);
        tick(1000);
        chk("dim_hold_lvl",   dim_level, 2'd2);
        chk("dim_hold_state", dut.r_state, ST_DIM);
        chk("dim_hold_rgb",   rgb_out, 8'h09);
        chk("dim_hold_pause", pause, 1'b1);

        // release does not toggle; second press from DIM returns to RUN
        btn_pause = 1'b0;
        tick(3);
        chk("release_up", user_paused, 1'b1);
        btn_pause = 1'b1;
        tick(2);
        chk("unp_pre_dim", dim_level, 2'd2);
        tick(1);
        chk("unp_up",    user_paused, 1'b0);
        chk("unp_dim",   dim_level, 2'd0);
        chk("unp_state", dut.r_state, ST_RUN);
        chk("unp_pause", pause, 1'b0);
        tick(1);
        chk("unp_rgb", rgb_out, 8'hFF);
        rgb_in = 8'hA5;
        tick(1);
        chk("run_rgb_a5", rgb_out, 8'hA5);
        btn_pause = 1'b0;
        tick(5);

        // external requests: pause only, never dim
        req    = 3'b010;
        req_en = 3'b111;
        dim_seen = 2'd0;
        tick(1);
        chk("req_pause", pause, 1'b1);
        tick(500);
        chk("req_dim_seen", dim_seen, 2'd0);
        chk("req_state",    dut.r_state, ST_RUN);
        chk("req_up",       user_paused, 1'b0);
        chk("req_pause_hold", pause, 1'b1);
        req_en = 3'b101;
        tick(1);
        chk("req_masked", pause, 1'b0);
        req = 3'b001;
        tick(1);
        chk("req0_en", pause, 1'b1);
        req = 3'b000;
        tick(1);
        chk("req_clear", pause, 1'b0);
        req_en = 3'b111;
        rgb_in = 8'hFF;
        tick(2);

        // reset pulse mid-fade with button held high
        btn_pause = 1'b1;
        tick(3);
        chk("rf_up", user_paused, 1'b1);
        tick(102);
        chk("rf_fade", dut.r_state, ST_FADE);
        reset_n = 1'b0;
        #1;
        chk("rf_rst_up",    user_paused, 1'b0);
        chk("rf_rst_pause", pause, 1'b0);
        chk("rf_rst_dim",   dim_level, 2'd0);
        chk("rf_rst_rgb",   rgb_out, 8'h00);
        chk("rf_rst_state", dut.r_state, ST_RUN);
        tick(2);
        reset_n  = 1'b1;
        dim_seen = 2'd0;
        tick(20);
        chk("rf_post_up",    user_paused, 1'b0);
        chk("rf_post_pause", pause, 1'b0);
        chk("rf_post_state", dut.r_state, ST_RUN);
        chk("rf_post_dim",   dim_seen, 2'd0);

        // un-pause edge landing on the HOLD->FADE boundary wins
        btn_pause = 1'b0;
        tick(5);
        btn_pause = 1'b1;
        tick(3);
        chk("bd_hold", dut.r_state, ST_HOLD);
        btn_pause = 1'b0;
        tick(97);
        btn_pause = 1'b1;
        dim_seen  = 2'd0;
        tick(2);
        chk("bd_pre_state", dut.r_state, ST_HOLD);
        chk("bd_pre_up",    user_paused, 1'b1);
        tick(1);
        chk("bd_state", dut.r_state, ST_RUN);
        chk("bd_up",    user_paused, 1'b0);
        chk("bd_dim",   dim_level, 2'd0);
        tick(200);
        chk("bd_dim_seen",   dim_seen, 2'd0);
        chk("bd_state_late", dut.r_state, ST_RUN);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
